// File: rtl/boot_loader_pkg.sv
// Shared types and helpers for the UART boot loader: FSM state encoding,
// failure codes and the bytes-per-word calculation.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OVERRUN = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;

    // Number of UART bytes that make up one memory word.
    function automatic int bytes_per_word(input int word_width);
        return word_width / 8;
    endfunction

endpackage

// File: rtl/uart_boot_loader_byte_packer.sv
// MSB-first shift assembler: collects NBYTES bytes into one word and pulses
// word_valid (combinationally) in the cycle the final byte is presented, so
// the assembled word can be captured on that same clock edge.
module byte_packer #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic [NBYTES*8-1:0]   word,
    output logic                  word_valid
);

    generate
        if (NBYTES == 1) begin : g_single
            assign word       = byte_in;
            assign word_valid = byte_valid;
        end else begin : g_multi
            localparam int CNT_W = $clog2(NBYTES);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

            logic [(NBYTES-1)*8-1:0] shift;
            logic [CNT_W-1:0]        count;

            // The newest byte lands in the low lane; older bytes come from the shifter.
            assign word       = {shift, byte_in};
            assign word_valid = byte_valid && (count == LAST);

            // Byte counter and shifter; stale bytes are overwritten by the next word.
            always_ff @(posedge clk or posedge rst) begin
                // NOTE: sequential state uses non-blocking assignments so every
                // register in the block samples its pre-edge value.
                if (rst) begin
                    shift <= '0;
                    count <= '0;
                end else if (clear) begin
                    shift <= '0;
                    count <= '0;
                end else if (byte_valid) begin
                    shift <= word[(NBYTES-1)*8-1:0];
                    count <= (count == LAST) ? '0 : count + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/uart_boot_loader.sv
// UART byte stream to memory word writer. Optionally framed by a word-count
// header and trailing 8-bit checksum; holds the CPU in reset during a load.
module uart_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int                    WORD_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 25,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter bit                    HEADER_EN  = 1'b1,
    parameter int                    LEN_BYTES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-1:0] word_count
);

    localparam int BPW   = bytes_per_word(WORD_WIDTH);
    localparam int LEN_W = LEN_BYTES * 8;
    localparam int CMP_W = (LEN_W > ADDR_WIDTH) ? LEN_W : ADDR_WIDTH;

    state_t state, state_next;

    logic                  load_en_d;
    logic                  load_go;
    logic                  skid_full;
    logic [7:0]            skid_byte;
    logic                  byte_avail;
    logic [7:0]            byte_sel;
    logic                  len_byte_valid;
    logic                  data_byte_valid;
    logic [LEN_W-1:0]      len_word;
    logic                  len_valid;
    logic [WORD_WIDTH-1:0] data_word;
    logic                  data_valid;
    logic [LEN_W-1:0]      len;
    logic [7:0]            csum;
    logic                  ack_fire;
    logic                  overrun;
    logic [ADDR_WIDTH-1:0] wc_inc;
    logic                  last_word;

    // A load starts only from IDLE on the rising edge of load_en.
    assign load_go = load_en && !load_en_d && (state == IDLE);

    // A buffered byte is always older than the one on rx, so it is consumed first.
    assign byte_avail = skid_full | rx_valid;
    assign byte_sel   = skid_full ? skid_byte : rx_byte;

    assign len_byte_valid  = (state == LEN)  && load_en && byte_avail;
    assign data_byte_valid = (state == DATA) && load_en && byte_avail;

    assign ack_fire  = (state == WRITE) && mem_req && mem_ack;
    assign overrun   = (state == WRITE) && rx_valid && skid_full;
    assign wc_inc    = word_count + ADDR_WIDTH'(1);
    assign last_word = HEADER_EN && (CMP_W'(wc_inc) == CMP_W'(len));

    assign mem_write_en = mem_req;

    byte_packer #(.NBYTES(LEN_BYTES)) u_len_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_go),
        .byte_in    (byte_sel),
        .byte_valid (len_byte_valid),
        .word       (len_word),
        .word_valid (len_valid)
    );

    byte_packer #(.NBYTES(BPW)) u_data_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_go),
        .byte_in    (byte_sel),
        .byte_valid (data_byte_valid),
        .word       (data_word),
        .word_valid (data_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decision; a dropped load_en wins over incoming bytes.
    always_comb begin
        // NOTE: assigning a default before the case keeps this block free of
        // inferred latches when a branch leaves the state unchanged.
        state_next = state;
        case (state)
            IDLE: if (load_go) state_next = HEADER_EN ? LEN : DATA;
            LEN: begin
                if (!load_en)       state_next = IDLE;
                else if (len_valid) state_next = (len_word == '0) ? CSUM : DATA;
            end
            DATA: begin
                if (!load_en)        state_next = HEADER_EN ? IDLE : DONE;
                else if (data_valid) state_next = WRITE;
            end
            WRITE: begin
                if (overrun)         state_next = ERR;
                else if (ack_fire) begin
                    if (!load_en)       state_next = IDLE;
                    else if (last_word) state_next = CSUM;
                    else                state_next = DATA;
                end
            end
            CSUM: begin
                if (!load_en)        state_next = IDLE;
                else if (byte_avail) state_next = (byte_sel == csum) ? DONE : ERR;
            end
            DONE, ERR: if (!load_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy     = (state != IDLE);
        cpu_hold = !(state inside {IDLE, DONE, ERR});
    end

    // Datapath: skid buffer, checksum, length, memory port and sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_en_d  <= 1'b0;
            skid_full  <= 1'b0;
            skid_byte  <= '0;
            len        <= '0;
            csum       <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            word_count <= '0;
        end else begin
            load_en_d <= load_en;
            case (state)
                IDLE: begin
                    if (load_go) begin
                        skid_full  <= 1'b0;
                        len        <= '0;
                        csum       <= '0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        err_code   <= ERR_NONE;
                        word_count <= '0;
                    end
                end
                LEN: begin
                    if (len_valid) len <= len_word;
                end
                DATA: begin
                    if (!load_en) begin
                        skid_full <= 1'b0;
                        if (!HEADER_EN) done <= 1'b1;
                    end else if (byte_avail) begin
                        csum <= csum + byte_sel;
                        // A buffered byte was just consumed; a fresh rx byte refills it.
                        skid_full <= skid_full & rx_valid;
                        if (rx_valid) skid_byte <= rx_byte;
                        if (data_valid) begin
                            mem_data <= data_word;
                            mem_addr <= BASE_ADDR + word_count;
                            mem_req  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (ack_fire) begin
                        mem_req    <= 1'b0;
                        word_count <= wc_inc;
                    end
                    if (rx_valid) begin
                        if (skid_full) begin
                            mem_req  <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_OVERRUN;
                        end else begin
                            skid_full <= 1'b1;
                            skid_byte <= rx_byte;
                        end
                    end
                end
                CSUM: begin
                    if (load_en && byte_avail) begin
                        skid_full <= 1'b0;
                        if (byte_sel == csum) begin
                            done <= 1'b1;
                        end else begin
                            error    <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: a framed 16-bit instance driven from a vector
// table plus directed sequences, and a free-running 32-bit instance.
module tb_uart_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;

    // Framed instance (defaults: 16-bit words, 2-byte header, base 0).
    logic        load_en_f, mem_ack_f;
    logic        mem_req_f, mem_write_en_f, cpu_hold_f, busy_f, done_f, error_f;
    logic [24:0] mem_addr_f, word_count_f;
    logic [15:0] mem_data_f;
    logic [1:0]  err_code_f;

    // Free-running instance (32-bit words, base 0x100).
    logic        load_en_r, mem_ack_r;
    logic        mem_req_r, mem_write_en_r, cpu_hold_r, busy_r, done_r, error_r;
    logic [24:0] mem_addr_r, word_count_r;
    logic [31:0] mem_data_r;
    logic [1:0]  err_code_r;

    uart_boot_loader dut_f (
        .clk(clk), .rst(rst), .load_en(load_en_f), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .mem_ack(mem_ack_f), .mem_req(mem_req_f), .mem_write_en(mem_write_en_f),
        .mem_addr(mem_addr_f), .mem_data(mem_data_f), .cpu_hold(cpu_hold_f), .busy(busy_f),
        .done(done_f), .error(error_f), .err_code(err_code_f), .word_count(word_count_f)
    );

    uart_boot_loader #(
        .WORD_WIDTH(32), .ADDR_WIDTH(25), .BASE_ADDR(25'h100), .HEADER_EN(1'b0), .LEN_BYTES(2)
    ) dut_r (
        .clk(clk), .rst(rst), .load_en(load_en_r), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .mem_ack(mem_ack_r), .mem_req(mem_req_r), .mem_write_en(mem_write_en_r),
        .mem_addr(mem_addr_r), .mem_data(mem_data_r), .cpu_hold(cpu_hold_r), .busy(busy_r),
        .done(done_r), .error(error_r), .err_code(err_code_r), .word_count(word_count_r)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responders: ack a pending request after ack_delay negedges and log it.
    int          ack_delay_f = 3;
    int          ack_cnt_f;
    logic [24:0] wr_addr_f [$];
    logic [15:0] wr_data_f [$];

    initial begin
        mem_ack_f = 1'b0;
        ack_cnt_f = 0;
        forever begin
            @(negedge clk);
            if (rst || !mem_req_f) begin
                ack_cnt_f = 0;
                mem_ack_f = 1'b0;
            end else if (!mem_ack_f) begin
                ack_cnt_f++;
                if (ack_cnt_f >= ack_delay_f) begin
                    mem_ack_f = 1'b1;
                    wr_addr_f.push_back(mem_addr_f);
                    wr_data_f.push_back(mem_data_f);
                end
            end
        end
    end

    int          ack_cnt_r;
    logic [24:0] wr_addr_r [$];
    logic [31:0] wr_data_r [$];

    initial begin
        mem_ack_r = 1'b0;
        ack_cnt_r = 0;
        forever begin
            @(negedge clk);
            if (rst || !mem_req_r) begin
                ack_cnt_r = 0;
                mem_ack_r = 1'b0;
            end else if (!mem_ack_r) begin
                ack_cnt_r++;
                if (ack_cnt_r >= 2) begin
                    mem_ack_r = 1'b1;
                    wr_addr_r.push_back(mem_addr_r);
                    wr_data_r.push_back(mem_data_r);
                end
            end
        end
    end

    // One byte, then one idle cycle before the next call can drive again.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Bytes on consecutive cycles, MSB byte first.
    task automatic send_burst(input logic [31:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_byte  = bytes[31-8*i -: 8];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_end_f(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_f || error_f) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        string       name;
        int          n_bytes;
        logic [95:0] stream;     // left-aligned, first byte in [95:88]
        int          ack_delay;
        int          n_words;
        logic [47:0] words;      // left-aligned expected words, addresses 0,1,2
        logic        exp_done;
        logic        exp_error;
        logic [1:0]  exp_code;
    } frame_vec_t;

    frame_vec_t vecs [5];

    task automatic run_frame(input int k);
        frame_vec_t v;
        bit seen;
        v = vecs[k];
        ack_delay_f = v.ack_delay;
        wr_addr_f.delete();
        wr_data_f.delete();
        @(negedge clk);
        load_en_f = 1'b1;
        @(negedge clk);
        check({v.name, " busy_at_start"}, busy_f, 1);
        check({v.name, " cpu_hold_at_start"}, cpu_hold_f, 1);
        for (int i = 0; i < v.n_bytes; i++) send_byte(v.stream[95-8*i -: 8]);
        wait_end_f(seen);
        check({v.name, " finished_in_time"}, seen, 1);
        @(negedge clk);
        check({v.name, " done"}, done_f, v.exp_done);
        check({v.name, " error"}, error_f, v.exp_error);
        check({v.name, " err_code"}, err_code_f, v.exp_code);
        check({v.name, " word_count"}, word_count_f, v.n_words);
        check({v.name, " cpu_hold_end"}, cpu_hold_f, 0);
        check({v.name, " write_count"}, wr_data_f.size(), v.n_words);
        for (int i = 0; i < v.n_words && i < wr_data_f.size(); i++) begin
            check({v.name, " wr_addr"}, wr_addr_f[i], i);
            check({v.name, " wr_data"}, wr_data_f[i], v.words[47-16*i -: 16]);
        end
        load_en_f = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({v.name, " idle_busy"}, busy_f, 0);
        check({v.name, " done_sticky"}, done_f, v.exp_done);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;

        // Checksums: 12+34+AB+CD = 0x1BE -> BE; 01+..+06 = 0x15; 5A+A5 = 0xFF.
        vecs[0] = '{name:"frame_ok", n_bytes:7, stream:96'h0002_1234_ABCD_BE00_0000_0000,
                    ack_delay:3, n_words:2, words:48'h1234_ABCD_0000,
                    exp_done:1'b1, exp_error:1'b0, exp_code:2'd0};
        vecs[1] = '{name:"frame_bad_csum", n_bytes:7, stream:96'h0002_1234_ABCD_BF00_0000_0000,
                    ack_delay:3, n_words:2, words:48'h1234_ABCD_0000,
                    exp_done:1'b0, exp_error:1'b1, exp_code:2'd2};
        vecs[2] = '{name:"ack_with_rx", n_bytes:9, stream:96'h0003_0102_0304_0506_1500_0000,
                    ack_delay:2, n_words:3, words:48'h0102_0304_0506,
                    exp_done:1'b1, exp_error:1'b0, exp_code:2'd0};
        vecs[3] = '{name:"zero_len", n_bytes:3, stream:96'h0000_0000_0000_0000_0000_0000,
                    ack_delay:3, n_words:0, words:48'h0,
                    exp_done:1'b1, exp_error:1'b0, exp_code:2'd0};
        vecs[4] = '{name:"zero_len_bad", n_bytes:3, stream:96'h0000_0100_0000_0000_0000_0000,
                    ack_delay:3, n_words:0, words:48'h0,
                    exp_done:1'b0, exp_error:1'b1, exp_code:2'd2};

        rst       = 1'b1;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        load_en_f = 1'b0;
        load_en_r = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst mem_req", mem_req_f, 0);
        check("rst mem_write_en", mem_write_en_f, 0);
        check("rst mem_addr", mem_addr_f, 0);
        check("rst mem_data", mem_data_f, 0);
        check("rst cpu_hold", cpu_hold_f, 0);
        check("rst busy", busy_f, 0);
        check("rst done", done_f, 0);
        check("rst error", error_f, 0);
        check("rst err_code", err_code_f, 0);
        check("rst word_count", word_count_f, 0);
        check("rst free mem_req", mem_req_r, 0);
        check("rst free busy", busy_r, 0);
        check("rst free mem_addr", mem_addr_r, 0);

        for (int k = 0; k < 5; k++) run_frame(k);

        // Overrun: ack held off, two bytes arrive during WRITE.
        ack_delay_f = 10;
        @(negedge clk);
        load_en_f = 1'b1;
        @(negedge clk);
        send_byte(8'h00);
        send_byte(8'h02);
        send_burst(32'h1122_3344, 4);
        check("ovr error", error_f, 1);
        check("ovr err_code", err_code_f, 1);
        check("ovr done", done_f, 0);
        check("ovr mem_req", mem_req_f, 0);
        check("ovr cpu_hold", cpu_hold_f, 0);
        check("ovr busy", busy_f, 1);
        check("ovr word_count", word_count_f, 0);
        load_en_f = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ovr idle busy", busy_f, 0);
        check("ovr error sticky", error_f, 1);
        check("ovr err_code sticky", err_code_f, 1);

        // Free-running 32-bit load: one full word, then a partial byte dropped.
        wr_addr_r.delete();
        wr_data_r.delete();
        @(negedge clk);
        load_en_r = 1'b1;
        @(negedge clk);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (word_count_r == 25'd1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("free first word written", seen, 1);
        send_byte(8'h01);
        @(negedge clk);
        check("free busy in data", busy_r, 1);
        check("free cpu_hold in data", cpu_hold_r, 1);
        load_en_r = 1'b0;
        @(negedge clk);
        check("free done", done_r, 1);
        check("free cpu_hold done", cpu_hold_r, 0);
        check("free error", error_r, 0);
        @(negedge clk);
        check("free idle busy", busy_r, 0);
        check("free done sticky", done_r, 1);
        check("free word_count", word_count_r, 1);
        check("free write_count", wr_data_r.size(), 1);
        if (wr_data_r.size() > 0) begin
            check("free wr_addr", wr_addr_r[0], 25'h100);
            check("free wr_data", wr_data_r[0], 32'hDEADBEEF);
        end

        // Reset while the second word's write is pending, then a fresh load.
        ack_delay_f = 3;
        wr_addr_f.delete();
        wr_data_f.delete();
        @(negedge clk);
        load_en_f = 1'b1;
        @(negedge clk);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (word_count_f == 25'd1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstw first word written", seen, 1);
        ack_delay_f = 1000;
        send_byte(8'h33);
        send_byte(8'h44);
        check("rstw mem_req", mem_req_f, 1);
        check("rstw mem_write_en", mem_write_en_f, 1);
        check("rstw mem_addr", mem_addr_f, 1);
        check("rstw mem_data", mem_data_f, 16'h3344);
        check("rstw cpu_hold", cpu_hold_f, 1);
        #2;
        rst       = 1'b1;
        load_en_f = 1'b0;
        #1;
        check("rstw async mem_req", mem_req_f, 0);
        check("rstw async mem_write_en", mem_write_en_f, 0);
        check("rstw async word_count", word_count_f, 0);
        check("rstw async busy", busy_f, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ack_delay_f = 3;
        wr_addr_f.delete();
        wr_data_f.delete();
        load_en_f = 1'b1;
        @(negedge clk);
        check("fresh busy", busy_f, 1);
        check("fresh word_count", word_count_f, 0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_byte(8'hFF);
        wait_end_f(seen);
        check("fresh finished_in_time", seen, 1);
        @(negedge clk);
        check("fresh done", done_f, 1);
        check("fresh error", error_f, 0);
        check("fresh word_count end", word_count_f, 1);
        check("fresh write_count", wr_data_f.size(), 1);
        if (wr_data_f.size() > 0) begin
            check("fresh wr_addr", wr_addr_f[0], 0);
            check("fresh wr_data", wr_data_f[0], 16'h5AA5);
        end
        load_en_f = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
